// File: rtl/fa_fault_pkg.sv
// Shared types, constants and the reference adder function for the full-adder fault campaign.
package fa_fault_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned ERR_W       = 4;
  localparam int unsigned MCNT_W      = 7;

  localparam logic [ERR_W-1:0] ERR_NONE = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Operand bundle driven to the adder; a is the MSB of the vector index.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } fa_vec_t;

  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// Fault-free full adder used as the reference for every compared vector.
module fa_golden_model
  import fa_fault_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign {cout, sum} = fa_golden(a, b, c);

endmodule

// File: rtl/fa_fault_campaign.sv
// Sweeps every fault code over all eight operand vectors of one adder and
// records which codes are detected and how many (fault,vector) pairs mismatch.
module fa_fault_campaign
  import fa_fault_pkg::*;
#(
  parameter int unsigned NUM_FAULTS    = 8,
  parameter int unsigned SETTLE_CYCLES = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  fa_a,
  output logic                  fa_b,
  output logic                  fa_c,
  output logic [ERR_W-1:0]      fa_err,
  input  logic                  fa_sum,
  input  logic                  fa_cout,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_FAULTS:0]   detected,
  output logic [MCNT_W-1:0]     mismatch_cnt,
  output logic                  golden_err
);

  localparam int unsigned DET_W = NUM_FAULTS + 1;
  localparam logic [MCNT_W-1:0] MCNT_MAX = 7'd127;

  state_t               state_q, state_d;
  logic [2:0]           v_q, v_d;
  logic [ERR_W-1:0]     f_q, f_d;
  logic [3:0]           cnt_q, cnt_d;
  fa_vec_t              vec_q, vec_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DET_W-1:0]     det_q, det_d;
  logic [MCNT_W-1:0]    mcnt_q, mcnt_d;
  logic                 gerr_q, gerr_d;

  logic                 gold_sum, gold_cout;
  logic                 mismatch_c;
  logic                 last_pair_c;
  logic [2:0]           v_inc;
  logic [ERR_W-1:0]     f_inc;

  fa_golden_model u_golden (
    .a    (vec_q.a),
    .b    (vec_q.b),
    .c    (vec_q.c),
    .sum  (gold_sum),
    .cout (gold_cout)
  );

  assign mismatch_c  = ({fa_cout, fa_sum} != {gold_cout, gold_sum});
  assign last_pair_c = (f_q == ERR_W'(NUM_FAULTS)) && (v_q == 3'(NUM_VECTORS - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= ERR_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      det_q   <= '0;
      mcnt_q  <= '0;
      gerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      det_q   <= det_d;
      mcnt_q  <= mcnt_d;
      gerr_q  <= gerr_d;
    end
  end

  // Next-state logic; abort wins over start and over normal sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = SETTLE;
      SETTLE:  if (abort) state_d = IDLE;
               else if (cnt_q == 4'd1) state_d = CHECK;
      CHECK:   if (abort) state_d = IDLE;
               else if (last_pair_c) state_d = DONE;
               else state_d = SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of all registered outputs and counters.
  always_comb begin
    v_d    = v_q;
    f_d    = f_q;
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    err_d  = err_q;
    busy_d = busy_q;
    done_d = 1'b0;
    det_d  = det_q;
    mcnt_d = mcnt_q;
    gerr_d = gerr_q;
    v_inc  = v_q + 3'd1;
    f_inc  = (v_q == 3'(NUM_VECTORS - 1)) ? f_q + ERR_W'(1) : f_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          v_d    = '0;
          f_d    = '0;
          cnt_d  = 4'(SETTLE_CYCLES);
          vec_d  = '0;
          err_d  = ERR_NONE;
          busy_d = 1'b1;
          det_d  = '0;
          mcnt_d = '0;
          gerr_d = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          vec_d  = '0;
          err_d  = ERR_NONE;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          vec_d  = '0;
          err_d  = ERR_NONE;
          busy_d = 1'b0;
        end else begin
          if (mismatch_c) begin
            for (int unsigned i = 0; i < DET_W; i++) begin
              if (f_q == ERR_W'(i)) det_d[i] = 1'b1;
            end
            if (mcnt_q != MCNT_MAX) mcnt_d = mcnt_q + 7'd1;
            if (f_q == ERR_NONE) gerr_d = 1'b1;
          end
          if (last_pair_c) begin
            done_d = 1'b1;
          end else begin
            v_d   = v_inc;
            f_d   = f_inc;
            err_d = f_inc;
            vec_d = fa_vec_t'(v_inc);
            cnt_d = 4'(SETTLE_CYCLES);
          end
        end
      end
      DONE: begin
        vec_d  = '0;
        err_d  = ERR_NONE;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign fa_a         = vec_q.a;
  assign fa_b         = vec_q.b;
  assign fa_c         = vec_q.c;
  assign fa_err       = err_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign detected     = det_q;
  assign mismatch_cnt = mcnt_q;
  assign golden_err   = gerr_q;

endmodule

// File: tb/tb_fa_fault_campaign.sv
// Directed bench for the fault campaign sequencer, driving a behavioural fault-injectable adder.
module tb_fa_fault_campaign;
  import fa_fault_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, start1;
  logic       broken;

  logic       fa_a, fa_b, fa_c, fa_sum, fa_cout;
  logic [3:0] fa_err;
  logic       busy, done, golden_err;
  logic [8:0] detected;
  logic [6:0] mismatch_cnt;

  logic       fa1_a, fa1_b, fa1_c, fa1_sum, fa1_cout;
  logic [3:0] fa1_err;
  logic       busy1, done1, golden_err1;
  logic [8:0] detected1;
  logic [6:0] mismatch_cnt1;

  logic       ref_sum, ref_cout;
  bit         seen [16][8];
  bit         clr_seen;
  bit         err_over;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Adder with one fault per code; 'broken' forces sum high regardless of code.
  function automatic logic [1:0] faulty_fa(input logic a, input logic b, input logic c,
                                           input logic [3:0] err, input bit brk);
    logic ai, ci, s, co;
    ai = a;
    ci = c;
    if (err == 4'd5) ai = 1'b0;
    if (err == 4'd8) ci = 1'b1;
    s  = ai ^ b ^ ci;
    co = (ai & b) | (ai & ci) | (b & ci);
    case (err)
      4'd1: s  = 1'b0;
      4'd2: s  = 1'b1;
      4'd3: co = 1'b0;
      4'd4: co = 1'b1;
      4'd6: co = ai & b;
      4'd7: if (ai) s = 1'b0;
      default: ;
    endcase
    if (brk) begin
      s  = 1'b1;
      co = (a & b) | (a & c) | (b & c);
    end
    return {co, s};
  endfunction

  assign {fa_cout, fa_sum}   = faulty_fa(fa_a, fa_b, fa_c, fa_err, broken);
  assign {fa1_cout, fa1_sum} = faulty_fa(fa1_a, fa1_b, fa1_c, fa1_err, 1'b0);

  fa_fault_campaign #(.NUM_FAULTS(8), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_err(fa_err),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .detected(detected),
    .mismatch_cnt(mismatch_cnt), .golden_err(golden_err)
  );

  fa_fault_campaign #(.NUM_FAULTS(8), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_c(fa1_c), .fa_err(fa1_err),
    .fa_sum(fa1_sum), .fa_cout(fa1_cout),
    .busy(busy1), .done(done1), .detected(detected1),
    .mismatch_cnt(mismatch_cnt1), .golden_err(golden_err1)
  );

  fa_golden_model u_ref (
    .a(fa_a), .b(fa_b), .c(fa_c), .sum(ref_sum), .cout(ref_cout)
  );

  // Records which (code,vector) pairs the adder gets wrong while a campaign runs.
  always @(negedge clk) begin
    if (clr_seen) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 8; j++) seen[i][j] = 1'b0;
    end else if (busy && ({fa_cout, fa_sum} !== {ref_cout, ref_sum})) begin
      seen[fa_err][{fa_a, fa_b, fa_c}] = 1'b1;
    end
    if (fa_err > 4'd8 || fa1_err > 4'd8) err_over = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_seen();
    @(posedge clk);
    clr_seen = 1'b1;
    @(negedge clk);
    #1 clr_seen = 1'b0;
  endtask

  function automatic int code_hits(input int code);
    int n = 0;
    for (int j = 0; j < 8; j++) n += int'(seen[code][j]);
    return n;
  endfunction

  // Starts u_dut and returns cycles from the accept edge until done is observed.
  task automatic run_campaign(input bit pulse_start, output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 1000) begin
      if (pulse_start) start = (lat % 5 == 0);
      @(posedge clk);
      #1 lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_after_done(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check({tag, "_err_idle"},   32'(fa_err), 32'd0);
    check({tag, "_ops_idle"},   32'({fa_a, fa_b, fa_c}), 32'd0);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_detected"}, 32'(detected), 32'h1FE);
    check({tag, "_mcnt"},     32'(mismatch_cnt), 32'd28);
    check({tag, "_gerr"},     32'(golden_err), 32'd0);
  endtask

  initial begin
    int lat;
    int exp_hits [9] = '{0, 4, 4, 4, 4, 4, 2, 2, 4};
    bit done_seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; broken = 1'b0;
    clr_seen = 1'b0; err_over = 1'b0;
    #12;
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_det",    32'(detected), 32'd0);
    check("rst_mcnt",   32'(mismatch_cnt), 32'd0);
    check("rst_gerr",   32'(golden_err), 32'd0);
    check("rst_err",    32'(fa_err), 32'd0);
    check("rst_ops",    32'({fa_a, fa_b, fa_c}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Baseline campaign with per-code mismatch accounting.
    clear_seen();
    run_campaign(1'b0, lat);
    check("t1_latency", 32'(lat), 32'd216);
    check_results("t1");
    for (int k = 0; k < 9; k++) check($sformatf("t1_hits_code%0d", k), 32'(code_hits(k)), 32'(exp_hits[k]));
    check_after_done("t1");

    // Adder with sum stuck high: the baseline code must be flagged.
    broken = 1'b1;
    run_campaign(1'b0, lat);
    check("t3_latency", 32'(lat), 32'd216);
    check("t3_gerr",    32'(golden_err), 32'd1);
    check("t3_det",     32'(detected), 32'h1FF);
    check("t3_mcnt",    32'(mismatch_cnt), 32'd36);
    broken = 1'b0;
    @(negedge clk);

    // Abort 50 cycles in, then a clean rerun.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_err",  32'(fa_err), 32'd0);
    check("t4_abort_ops",  32'({fa_a, fa_b, fa_c}), 32'd0);
    check("t4_abort_done", 32'(done), 32'd0);
    done_seen = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1 if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    check("t4_stays_idle", 32'(done_seen), 32'd0);
    run_campaign(1'b0, lat);
    check("t4_rerun_latency", 32'(lat), 32'd216);
    check_results("t4_rerun");
    check_after_done("t4");

    // Repeated start while busy must not restart or stretch the run.
    run_campaign(1'b1, lat);
    check("t5_latency", 32'(lat), 32'd216);
    check_results("t5");
    check_after_done("t5");

    // Asynchronous reset in the middle of a settle window.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_err",  32'(fa_err), 32'd0);
    check("t6_rst_ops",  32'({fa_a, fa_b, fa_c}), 32'd0);
    check("t6_rst_det",  32'(detected), 32'd0);
    check("t6_rst_mcnt", 32'(mismatch_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    check("t6_no_done_after_rst", 32'(done_seen), 32'd0);

    // Single-cycle settle variant.
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    check("t6_s1_latency", 32'(lat), 32'd144);
    check("t6_s1_det",     32'(detected1), 32'h1FE);
    check("t6_s1_mcnt",    32'(mismatch_cnt1), 32'd28);
    check("t6_s1_gerr",    32'(golden_err1), 32'd0);

    check("err_code_range", 32'(err_over), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
